// File: rtl/branch_pkg.sv
// ----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the sequential branch comparison unit:
//   - RISC-V branch funct3 encodings
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - packed result record carried from the compare loop to the outputs
//   - helpers classifying funct3 and resolving the branch decision
// ----------------------------------------------------------------------------
package branch_pkg;

  // RISC-V branch condition encodings (instruction bits 14:12).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // FSM state encoding, kept as plain constants so older tools and
  // waveform viewers that key on raw values keep working.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Everything the unit presents alongside out_valid.
  typedef struct packed {
    logic taken;
    logic illegal;
    logic eq;
    logic lt;
  } branch_result_t;

  localparam branch_result_t RESULT_CLEAR = '{taken: 1'b0, illegal: 1'b0, eq: 1'b0, lt: 1'b0};

  // Signed comparisons are BLT and BGE only.
  function automatic logic is_signed(input logic [2:0] f3);
    return (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

  // 010 and 011 are unassigned in the branch opcode space.
  function automatic logic is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  // Resolve the branch decision from the final equality / less-than flags.
  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       eq,
                                        input logic       lt);
    logic t;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_chunk_cmp.sv
// ----------------------------------------------------------------------------
// branch_chunk_cmp
// Purely combinational W-bit comparator used for one chunk per cycle.
// Ports:
//   a, b      : chunk operands (unsigned W-bit values)
//   sign_fix  : invert the MSB of both operands before the magnitude compare,
//               turning a two's-complement compare into an unsigned one
//               (only asserted for the top chunk of a signed branch)
//   eq        : a == b
//   lt        : a < b after the optional MSB inversion
// ----------------------------------------------------------------------------
module branch_chunk_cmp
  import branch_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sign_fix,
  output logic         eq,
  output logic         lt
);

  logic [W-1:0] mask_s;
  logic [W-1:0] a_fix_s;
  logic [W-1:0] b_fix_s;

  // Build a mask with only the MSB set when sign_fix is requested; written
  // bitwise so it also works for W == 1.
  always_comb begin
    mask_s        = '0;
    mask_s[W-1]   = sign_fix;
  end

  assign a_fix_s = a ^ mask_s;
  assign b_fix_s = b ^ mask_s;

  // Flipping the same bit on both sides never changes equality.
  assign eq = (a == b);
  assign lt = (a_fix_s < b_fix_s);

endmodule

// File: rtl/branch_compare_seq.sv
// ----------------------------------------------------------------------------
// branch_compare_seq
// Multi-cycle branch comparison unit covering BEQ/BNE/BLT/BGE/BLTU/BGEU at a
// configurable operand width. Operands are compared CHUNK bits per cycle,
// most-significant chunk first, stopping at the first differing chunk.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   in_valid   : request valid (funct3/rs1/rs2 meaningful)
//   in_ready   : unit idle and able to accept a request
//   funct3     : branch condition, RISC-V encoding
//   rs1, rs2   : operands A and B
//   out_valid  : result valid, held until out_ready is seen
//   out_ready  : consumer accepts the result
//   taken      : branch condition true
//   illegal    : funct3 was 010 or 011
//   eq_o       : rs1 == rs2
//   lt_o       : rs1 < rs2 under the selected signedness
//
// Latency (accept edge to first edge with out_valid high):
//   illegal funct3 -> 1, first differing chunk k (1-based from MSB) -> k+1,
//   equal operands -> NCHUNK+1.
// ----------------------------------------------------------------------------
module branch_compare_seq
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic            illegal,
  output logic            eq_o,
  output logic            lt_o
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(NCHUNK - 1);

  // Reject geometries where the operand does not split into whole chunks.
  if ((CHUNK < 1) || ((XLEN % CHUNK) != 0)) begin : g_bad_chunk
    $error("branch_compare_seq: XLEN must be a positive multiple of CHUNK");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      state_r,  state_s;
  logic [IDXW-1:0] idx_r,    idx_s;
  logic [XLEN-1:0] a_r,      a_s;
  logic [XLEN-1:0] b_r,      b_s;
  logic [2:0]      f3_r,     f3_s;
  logic            valid_r,  valid_s;
  branch_result_t  res_r,    res_s;

  // --------------------------------------------------------------------------
  // Chunk selection: slice the latched operands into an indexable array so the
  // current chunk is a plain array read instead of a variable part-select.
  // --------------------------------------------------------------------------
  logic [CHUNK-1:0] a_chunk_s [NCHUNK];
  logic [CHUNK-1:0] b_chunk_s [NCHUNK];

  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign a_chunk_s[gi] = a_r[gi*CHUNK +: CHUNK];
    assign b_chunk_s[gi] = b_r[gi*CHUNK +: CHUNK];
  end

  logic [CHUNK-1:0] cur_a_s;
  logic [CHUNK-1:0] cur_b_s;
  logic             sign_fix_s;
  logic             cmp_eq_s;
  logic             cmp_lt_s;
  logic             accept_s;

  assign cur_a_s = a_chunk_s[idx_r];
  assign cur_b_s = b_chunk_s[idx_r];

  // Only the top chunk carries the sign bit, so only it needs the MSB flip.
  assign sign_fix_s = is_signed(f3_r) && (idx_r == IDX_MAX);

  branch_chunk_cmp #(
    .W (CHUNK)
  ) u_chunk_cmp (
    .a        (cur_a_s),
    .b        (cur_b_s),
    .sign_fix (sign_fix_s),
    .eq       (cmp_eq_s),
    .lt       (cmp_lt_s)
  );

  // in_ready is derived from state and forced low during reset so no request
  // can be considered accepted while the unit is being cleared.
  assign in_ready = (state_r == ST_IDLE) && !rst;
  assign accept_s = in_valid && in_ready;

  // Next-state and datapath update for the IDLE / BUSY / DONE sequence.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    a_s     = a_r;
    b_s     = b_r;
    f3_s    = f3_r;
    valid_s = valid_r;
    res_s   = res_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          a_s   = rs1;
          b_s   = rs2;
          f3_s  = funct3;
          idx_s = IDX_MAX;
          if (is_illegal(funct3)) begin
            // Nothing to compare: report straight away.
            state_s = ST_DONE;
            valid_s = 1'b1;
            res_s   = '{taken: 1'b0, illegal: 1'b1, eq: 1'b0, lt: 1'b0};
          end else begin
            state_s = ST_BUSY;
            valid_s = 1'b0;
            res_s   = RESULT_CLEAR;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BUSY: begin
        if (!cmp_eq_s) begin
          // First differing chunk decides the ordering of the whole operand.
          state_s = ST_DONE;
          valid_s = 1'b1;
          res_s   = '{taken:   branch_taken(f3_r, 1'b0, cmp_lt_s),
                      illegal: 1'b0,
                      eq:      1'b0,
                      lt:      cmp_lt_s};
        end else if (idx_r == '0) begin
          // Every chunk matched.
          state_s = ST_DONE;
          valid_s = 1'b1;
          res_s   = '{taken:   branch_taken(f3_r, 1'b1, 1'b0),
                      illegal: 1'b0,
                      eq:      1'b1,
                      lt:      1'b0};
        end else begin
          idx_s = idx_r - IDXW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          // Result consumed; return to IDLE, a new request waits a cycle.
          state_s = ST_IDLE;
          valid_s = 1'b0;
          res_s   = RESULT_CLEAR;
          idx_s   = IDX_MAX;
        end else begin
          state_s = ST_DONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
        res_s   = RESULT_CLEAR;
        idx_s   = IDX_MAX;
      end
    endcase
  end

  // State and result registers; reset discards any in-flight comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_MAX;
      a_r     <= '0;
      b_r     <= '0;
      f3_r    <= 3'b000;
      valid_r <= 1'b0;
      res_r   <= RESULT_CLEAR;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      a_r     <= a_s;
      b_r     <= b_s;
      f3_r    <= f3_s;
      valid_r <= valid_s;
      res_r   <= res_s;
    end
  end

  assign out_valid = valid_r;
  assign taken     = res_r.taken;
  assign illegal   = res_r.illegal;
  assign eq_o      = res_r.eq;
  assign lt_o      = res_r.lt;

endmodule

// File: doc/branch_compare_seq.md
Name: branch_compare_seq

Overview:
- Parametrised, multi-cycle branch comparison unit. Generalises the fixed 32-bit single-function comparators to one block that covers all six RISC-V branch conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) at configurable width.
- Compares operands CHUNK bits per cycle, MSB chunk first, and terminates early on the first differing chunk.
- Sits between the decode/register-read stage and the PC-select logic, with valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, operand width in bits.
- CHUNK, 8, bits compared per cycle. XLEN % CHUNK != 0 is an elaboration error.
- NCHUNK, XLEN/CHUNK, derived localparam. Not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- funct3  in  3  branch condition, RISC-V encoding.
- rs1  in  XLEN  operand A.
- rs2  in  XLEN  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- taken  out  1  branch condition true.
- illegal  out  1  funct3 is 010 or 011.
- eq_o  out  1  rs1 == rs2 (debug/forwarding).
- lt_o  out  1  rs1 < rs2 under the selected signedness.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, out_valid=0, taken=0, illegal=0, eq_o=0, lt_o=0, chunk index=NCHUNK-1. in_ready=0 while rst is high.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch rs1, rs2, funct3 and set idx=NCHUNK-1.
  - If funct3 is illegal, go to DONE with illegal=1, taken=0, eq_o=0, lt_o=0.
  - Otherwise go to BUSY.
- State BUSY:
  - in_ready=0. Compare chunk idx of A and B as unsigned CHUNK-bit values.
  - For signed funct3 (100/101) on chunk NCHUNK-1, invert the MSB of both chunks before comparing.
  - Chunks differ: register eq=0, lt=(A_chunk<B_chunk), go to DONE.
  - Chunks equal and idx==0: register eq=1, lt=0, go to DONE.
  - Otherwise idx<=idx-1 and stay in BUSY.
- State DONE:
  - out_valid=1, in_ready=0.
  - taken by funct3: 000:eq, 001:!eq, 100/110:lt, 101/111:!lt.
  - All outputs stay stable until out_ready is sampled high, then go to IDLE.
  - No new request is accepted in the same cycle (no overlap).
- Latency, counted in cycles from the accept edge to the first edge with out_valid high:
  - Illegal funct3: 1.
  - First differing chunk k (counted from MSB, 1-based): k+1.
  - Equal operands: NCHUNK+1.
  - XLEN=32, CHUNK=8 gives a worst case of 5.
- CHUNK==XLEN: exactly one BUSY cycle, fixed latency 2.
- out_ready held high while waiting in BUSY has no effect. The result is presented for at least one cycle.
- Reset asserted mid-BUSY or mid-DONE: immediate return to IDLE, outputs cleared, in-flight result discarded and never presented.
- Operands are captured at accept. Changes on rs1/rs2/funct3 after accept have no effect.
- Throughput: at most one result per (latency+1) cycles.

Decomposition:
- Shared package branch_pkg:
  - funct3 localparams F3_BEQ=000, F3_BNE=001, F3_BLT=100, F3_BGE=101, F3_BLTU=110, F3_BGEU=111.
  - FSM state encoding IDLE/BUSY/DONE.
  - is_signed and is_illegal helper functions.
- One combinational sub-module, branch_chunk_cmp:
  - Parameter W.
  - Inputs a, b, sign_fix.
  - Outputs eq, lt.
  - Instantiated once. The parent muxes the current chunk into it.

Test Plan:
- BLT, rs1=0xFFFFFFFF, rs2=0x00000001 -> taken=1, lt_o=1, eq_o=0, out_valid 2 cycles after accept.
- BLTU, same operands -> taken=0, lt_o=0, latency 2.
- BEQ, rs1=rs2=0x12345678 -> taken=1, eq_o=1, latency 5. BNE with rs1=0x00000000, rs2=0x00000001 -> taken=1, latency 5.
- funct3=010 -> illegal=1, taken=0, latency 1. The next request, BGE with rs1=0x80000000, rs2=0x7FFFFFFF -> taken=0, latency 2.
- Backpressure: BGEU with out_ready=0 for 3 cycles after out_valid -> taken/eq_o/lt_o stable, in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
- rst pulsed during BUSY of a BEQ on equal operands (cycle 2 after accept) -> out_valid never asserts, outputs 0. A fresh BNE after reset completes with the correct result.
